mem_wb_fifo: RTL and testbench

Parametrised successor to the MEM/WB pipeline register: a DEPTH-entry, valid/ready-handshaked writeback queue between the memory stage and the register file. It decouples MEM from WB when writeback is back-pressured, drops writes to x0 at entry, and supports a synchronous flush. It also provides a combinational forwarding lookup over all queued writes so ID/EX can bypass results that have not yet retired.

---
 rtl/mem_wb_fifo_if.sv | 36 +++
 rtl/mem_wb_fifo.sv | 92 +++++++++
 tb/tb_mem_wb_fifo.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_fifo_if.sv
// MEM->WB writeback queue bundle: control, push/pop handshakes and the forwarding lookup.
// master drives the queue (MEM, WB and hazard side); slave is the queue itself.
interface mem_wb_fifo_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
);
  localparam int PTR_W = $clog2(DEPTH);

  logic              rdy;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_wd;
  logic              in_wreg;
  logic [DATA_W-1:0] in_wdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_wd;
  logic              out_wreg;
  logic [DATA_W-1:0] out_wdata;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output rdy, flush, in_valid, in_wd, in_wreg, in_wdata, out_ready, fwd_addr,
    input  in_ready, out_valid, out_wd, out_wreg, out_wdata, count, fwd_hit, fwd_data
  );

  modport slave (
    input  rdy, flush, in_valid, in_wd, in_wreg, in_wdata, out_ready, fwd_addr,
    output in_ready, out_valid, out_wd, out_wreg, out_wdata, count, fwd_hit, fwd_data
  );
endinterface

// File: rtl/mem_wb_fifo.sv
// DEPTH-entry MEM->WB writeback queue with x0 suppression and youngest-match forwarding; 1-cycle push-to-head latency, no fall-through.
// Backpressure: in_ready drops when full or rdy is low; the head is held until out_ready while rdy is high.
module mem_wb_fifo #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_wb_fifo_if.slave   q
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]    rd_q, rd_d, wr_q, wr_d;
  logic [PTR_W:0]    cnt;
  logic [PTR_W-1:0]  rd_idx, wr_idx, slot;
  logic [ADDR_W-1:0] wd_mem   [DEPTH];
  logic              wreg_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              empty, full, push, pop;
  logic              hit;
  logic [DATA_W-1:0] hit_data;

  assign rd_idx = rd_q[PTR_W-1:0];
  assign wr_idx = wr_q[PTR_W-1:0];
  assign cnt    = wr_q - rd_q;
  assign empty  = (rd_q == wr_q);
  assign full   = (rd_idx == wr_idx) && (rd_q[PTR_W] != wr_q[PTR_W]);

  assign q.in_ready  = rst && q.rdy && !full;
  assign q.out_valid = q.rdy && !empty;
  assign q.count     = cnt;

  assign push = q.in_valid && q.in_ready && !q.flush;
  assign pop  = q.out_valid && q.out_ready && !q.flush;

  assign q.out_wd    = q.out_valid ? wd_mem[rd_idx]   : '0;
  assign q.out_wreg  = q.out_valid ? wreg_mem[rd_idx] : 1'b0;
  assign q.out_wdata = q.out_valid ? data_mem[rd_idx] : '0;

  always_comb begin
    rd_d = rd_q;
    wr_d = wr_q;
    if (q.flush) begin
      rd_d = '0;
      wr_d = '0;
    end else begin
      if (push) wr_d = wr_q + (PTR_W+1)'(1);
      if (pop)  rd_d = rd_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end

  // Storage is never cleared; occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      wd_mem[wr_idx]   <= q.in_wd;
      wreg_mem[wr_idx] <= q.in_wreg && (q.in_wd != '0);
      data_mem[wr_idx] <= q.in_wdata;
    end
  end

  // Walk oldest to youngest so the last match found is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    slot     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_idx + PTR_W'(i);
      if (((PTR_W+1)'(i) < cnt) && wreg_mem[slot] && (wd_mem[slot] == q.fwd_addr)) begin
        hit      = 1'b1;
        hit_data = data_mem[slot];
      end
    end
    if (q.fwd_addr == '0) begin
      hit      = 1'b0;
      hit_data = '0;
    end
  end

  assign q.fwd_hit  = hit;
  assign q.fwd_data = hit_data;
endmodule

// File: tb/tb_mem_wb_fifo.sv
// Directed bench for mem_wb_fifo: a DEPTH=2 queue for fill/flush/pause/reset cases,
// a DEPTH=4 queue for streaming wrap and x0/forwarding cases.
// Checks are evaluated at the call site and tallied by ck.
module tb_mem_wb_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_wb_fifo_if #(.ADDR_W(5), .DATA_W(32), .DEPTH(2)) a ();
    mem_wb_fifo_if #(.ADDR_W(5), .DATA_W(32), .DEPTH(4)) b ();

    mem_wb_fifo #(.ADDR_W(5), .DATA_W(32), .DEPTH(2)) u_d2 (.clk(clk), .rst(rst), .q(a.slave));
    mem_wb_fifo #(.ADDR_W(5), .DATA_W(32), .DEPTH(4)) u_d4 (.clk(clk), .rst(rst), .q(b.slave));

    task automatic ck(input string tag, input logic ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [4:0] wd, input logic [31:0] d);
        a.in_valid = 1'b1; a.in_wd = wd; a.in_wreg = 1'b1; a.in_wdata = d;
        tick();
        a.in_valid = 1'b0;
    endtask

    task automatic push_b(input logic [4:0] wd, input logic [31:0] d);
        b.in_valid = 1'b1; b.in_wd = wd; b.in_wreg = 1'b1; b.in_wdata = d;
        tick();
        b.in_valid = 1'b0;
    endtask

    initial begin
        a.rdy = 1'b1; a.flush = 1'b0; a.in_valid = 1'b1; a.in_wd = 5'd3; a.in_wreg = 1'b1;
        a.in_wdata = 32'h0; a.out_ready = 1'b0; a.fwd_addr = 5'd3;
        b.rdy = 1'b1; b.flush = 1'b0; b.in_valid = 1'b0; b.in_wd = 5'd0; b.in_wreg = 1'b0;
        b.in_wdata = 32'h0; b.out_ready = 1'b0; b.fwd_addr = 5'd0;

        #3;
        ck("rst_in_ready", a.in_ready === 1'b0);
        ck("rst_out_valid", a.out_valid === 1'b0);
        ck("rst_out_wd", a.out_wd === 5'd0);
        ck("rst_out_wreg", a.out_wreg === 1'b0);
        ck("rst_out_wdata", a.out_wdata === 32'd0);
        ck("rst_count", a.count === 2'd0);
        ck("rst_fwd_hit", a.fwd_hit === 1'b0);
        ck("rst_fwd_data", a.fwd_data === 32'd0);
        tick();
        ck("rst_hold_count", a.count === 2'd0);
        a.in_valid = 1'b0;
        tick();
        rst = 1'b1;

        tick();
        a.in_valid = 1'b1; a.in_wd = 5'd3; a.in_wreg = 1'b1; a.in_wdata = 32'hDEADBEEF;
        #1;
        ck("p1_in_ready", a.in_ready === 1'b1);
        ck("p1_no_fallthrough", a.out_valid === 1'b0);
        tick();
        a.in_valid = 1'b0;
        #1;
        ck("p1_out_valid", a.out_valid === 1'b1);
        ck("p1_out_wd", a.out_wd === 5'd3);
        ck("p1_out_wreg", a.out_wreg === 1'b1);
        ck("p1_out_wdata", a.out_wdata === 32'hDEADBEEF);
        ck("p1_count", a.count === 2'd1);
        ck("p1_fwd_hit", a.fwd_hit === 1'b1);
        ck("p1_fwd_data", a.fwd_data === 32'hDEADBEEF);
        a.out_ready = 1'b1;
        tick();
        a.out_ready = 1'b0;
        #1;
        ck("p1_pop_count", a.count === 2'd0);
        ck("p1_pop_valid", a.out_valid === 1'b0);
        ck("p1_pop_wd", a.out_wd === 5'd0);
        ck("p1_pop_wreg", a.out_wreg === 1'b0);
        ck("p1_pop_wdata", a.out_wdata === 32'd0);
        ck("p1_pop_fwd_hit", a.fwd_hit === 1'b0);
        ck("p1_pop_fwd_data", a.fwd_data === 32'd0);

        push_a(5'd1, 32'h11);
        push_a(5'd2, 32'h22);
        a.in_valid = 1'b1; a.in_wd = 5'd4; a.in_wdata = 32'h33;
        #1;
        ck("fill_count", a.count === 2'd2);
        ck("fill_in_ready", a.in_ready === 1'b0);
        tick();
        a.in_valid = 1'b0;
        #1;
        ck("fill_third_rejected", a.count === 2'd2);
        ck("fill_head_first", a.out_wdata === 32'h11);
        a.out_ready = 1'b1;
        tick();
        a.out_ready = 1'b0;
        #1;
        ck("drain1_count", a.count === 2'd1);
        ck("drain1_in_ready", a.in_ready === 1'b1);
        ck("drain1_head_wd", a.out_wd === 5'd2);
        ck("drain1_head_data", a.out_wdata === 32'h22);
        a.out_ready = 1'b1;
        tick();
        a.out_ready = 1'b0;
        #1;
        ck("drain2_count", a.count === 2'd0);

        b.out_ready = 1'b1;
        b.in_wreg = 1'b1;
        for (int k = 0; k < 40; k++) begin
            b.in_valid = 1'b1;
            b.in_wd = 5'(k % 31 + 1);
            b.in_wdata = 32'(k);
            #1;
            if (k > 0) begin
                ck("wrap_data", b.out_wdata === 32'(k - 1));
                ck("wrap_count", b.count === 3'd1);
            end
            tick();
        end
        b.in_valid = 1'b0;
        #1;
        ck("wrap_last_data", b.out_wdata === 32'd39);
        tick();
        b.out_ready = 1'b0;
        #1;
        ck("wrap_end_count", b.count === 3'd0);

        push_b(5'd0, 32'd5);
        push_b(5'd7, 32'd1);
        push_b(5'd7, 32'd2);
        b.fwd_addr = 5'd7;
        #1;
        ck("x0_count", b.count === 3'd3);
        ck("fwd7_hit", b.fwd_hit === 1'b1);
        ck("fwd7_data", b.fwd_data === 32'd2);
        b.fwd_addr = 5'd0;
        #1;
        ck("fwd0_hit", b.fwd_hit === 1'b0);
        ck("fwd0_data", b.fwd_data === 32'd0);
        b.fwd_addr = 5'd9;
        #1;
        ck("fwd9_hit", b.fwd_hit === 1'b0);
        ck("x0_head_wd", b.out_wd === 5'd0);
        ck("x0_head_wreg", b.out_wreg === 1'b0);
        ck("x0_head_wdata", b.out_wdata === 32'd5);
        b.out_ready = 1'b1;
        tick();
        b.out_ready = 1'b0;
        b.fwd_addr = 5'd7;
        #1;
        ck("x0_pop_count", b.count === 3'd2);
        ck("x0_next_wreg", b.out_wreg === 1'b1);
        ck("x0_next_wdata", b.out_wdata === 32'd1);
        ck("fwd7_after_pop", b.fwd_data === 32'd2);
        b.flush = 1'b1;
        tick();
        b.flush = 1'b0;
        #1;
        ck("b_flush_count", b.count === 3'd0);

        push_a(5'd1, 32'hA1);
        push_a(5'd2, 32'hA2);
        a.flush = 1'b1; a.in_valid = 1'b1; a.in_wd = 5'd6; a.in_wdata = 32'hA3; a.out_ready = 1'b1;
        tick();
        a.flush = 1'b0; a.in_valid = 1'b0; a.out_ready = 1'b0;
        #1;
        ck("flush_count", a.count === 2'd0);
        ck("flush_out_valid", a.out_valid === 1'b0);
        push_a(5'd1, 32'hB1);
        a.flush = 1'b1; a.in_valid = 1'b1; a.in_wd = 5'd6; a.in_wdata = 32'hB2; a.out_ready = 1'b1;
        tick();
        a.flush = 1'b0; a.in_valid = 1'b0; a.out_ready = 1'b0;
        #1;
        ck("flush_push_dropped", a.count === 2'd0);
        tick();
        ck("flush_stays_empty", a.out_valid === 1'b0);

        push_a(5'd5, 32'h55);
        a.rdy = 1'b0; a.in_valid = 1'b1; a.in_wd = 5'd8; a.in_wdata = 32'h88;
        a.out_ready = 1'b1; a.fwd_addr = 5'd5;
        for (int c = 0; c < 3; c++) begin
            #1;
            ck("pause_in_ready", a.in_ready === 1'b0);
            ck("pause_out_valid", a.out_valid === 1'b0);
            ck("pause_out_wdata", a.out_wdata === 32'd0);
            ck("pause_count", a.count === 2'd1);
            ck("pause_fwd_hit", a.fwd_hit === 1'b1);
            ck("pause_fwd_data", a.fwd_data === 32'h55);
            tick();
        end
        a.rdy = 1'b1; a.in_valid = 1'b0; a.out_ready = 1'b0;
        #1;
        ck("resume_out_valid", a.out_valid === 1'b1);
        ck("resume_out_wdata", a.out_wdata === 32'h55);

        rst = 1'b0;
        #1;
        ck("arst_count", a.count === 2'd0);
        ck("arst_out_valid", a.out_valid === 1'b0);
        ck("arst_fwd_hit", a.fwd_hit === 1'b0);
        ck("arst_in_ready", a.in_ready === 1'b0);
        tick();
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
